// File: rtl/xs3_pkg.sv
// xs3_pkg: shared constants, FSM state encoding and helpers for the binary-to-Excess-3 encoder
package xs3_pkg;
  localparam logic [3:0] XS3_BIAS = 4'd3;
  localparam logic [3:0] DABBLE_THR = 4'd5;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
  function automatic logic [63:0] xs3_nines(input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n && i < 16; i++) r[4*i+:4] = 4'hC;
    return r;
  endfunction
endpackage

// File: rtl/bin_to_xs3_seq_if.sv
// bin_to_xs3_seq_if: valid/ready input word and Excess-3 result bundle
interface bin_to_xs3_seq_if #(parameter int IN_W = 7, parameter int DIGITS = 2);
  logic in_valid;
  logic in_ready;
  logic [IN_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [4*DIGITS-1:0] out_xs3;
  logic out_ovf;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_xs3, out_ovf);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_xs3, out_ovf);
endinterface

// File: rtl/xs3_dabble_cell.sv
// xs3_dabble_cell: one double-dabble correction step on a BCD nibble
module xs3_dabble_cell
  import xs3_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);
  assign q_o = (d_i >= DABBLE_THR) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin_to_xs3_seq.sv
// bin_to_xs3_seq: iterative shift-and-add-3 binary to packed Excess-3 encoder, one bit per clock
module bin_to_xs3_seq
  import xs3_pkg::*;
#(
  parameter int IN_W = 7,
  parameter int DIGITS = 2
) (
  input logic clk,
  input logic rst_n,
  bin_to_xs3_seq_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int unsigned LIMIT = pow10(DIGITS);
  localparam logic [BW-1:0] NINES = BW'(xs3_nines(DIGITS));
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_DONE = DONE;
  logic [1:0] state_q, state_d;
  logic [IN_W-1:0] sh_q, sh_d;
  logic [BW-1:0] bcd_q, bcd_d, dab, shifted, biased;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [BW-1:0] out_xs3_q, out_xs3_d;
  logic out_ovf_q, out_ovf_d;
  logic accept, in_shift, last;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    xs3_dabble_cell u_cell (.d_i(bcd_q[4*g+:4]), .q_o(dab[4*g+:4]));
    assign biased[4*g+:4] = shifted[4*g+:4] + XS3_BIAS;
  end
  // The final shift result is biased on its way into the output register, so DONE needs no extra cycle.
  assign shifted = BW'({dab, sh_q[IN_W-1]});
  assign accept = (state_q == S_IDLE) && bus.in_valid;
  assign in_shift = state_q == S_SHIFT;
  assign last = in_shift && (cnt_q == '0);
  always_comb begin
    state_d = (state_q == S_IDLE) ? (bus.in_valid ? S_SHIFT : S_IDLE) :
              in_shift ? (last ? S_DONE : S_SHIFT) :
              (state_q == S_DONE) ? (bus.out_ready ? S_IDLE : S_DONE) : S_IDLE;
    sh_d = accept ? bus.in_data : in_shift ? sh_q << 1 : sh_q;
    bcd_d = accept ? '0 : in_shift ? shifted : bcd_q;
    cnt_d = accept ? CW'(IN_W - 1) : in_shift ? cnt_q - CW'(1) : cnt_q;
    ovf_d = accept ? (32'(bus.in_data) >= LIMIT) : ovf_q;
    out_xs3_d = last ? (ovf_q ? NINES : biased) : out_xs3_q;
    out_ovf_d = last ? ovf_q : out_ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      out_xs3_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      out_xs3_q <= out_xs3_d;
      out_ovf_q <= out_ovf_d;
    end
  end
  assign bus.in_ready = state_q == S_IDLE;
  assign bus.out_valid = state_q == S_DONE;
  assign bus.out_xs3 = out_xs3_q;
  assign bus.out_ovf = out_ovf_q;
endmodule
